// File: rtl/pipeline_sequencer.sv
// Pipeline control sequencer: gates the front end, bubbles ID/EX and holds EX
// during load-use hazards, multi-cycle MDU operations and halt.
module pipeline_sequencer #(
  parameter int MDU_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             S,
  input  logic             halt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_load,
  input  logic [4:0]       ex_rt,
  input  logic             mdu_start,
  output logic             front_le,
  output logic             idex_bubble,
  output logic             ex_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count
);

  localparam int DW = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MDU  = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic [DW-1:0]    r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_stall;
  logic             w_luh;
  logic             w_stall_inc;

  // Load-use hazard: EX load writes a register the ID instruction reads.
  assign w_luh = ex_load && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    front_le    = 1'b0;
    idex_bubble = 1'b1;
    ex_hold     = 1'b0;
    case (r_state)
      IDLE: begin
        if (S) w_next = RUN;
      end
      RUN: begin
        front_le    = ~w_luh;
        idex_bubble = w_luh;
        if (halt) begin
          w_next = HALT;
        end else if (mdu_start) begin
          w_next     = MDU;
          w_cnt_next = DW'(MDU_CYCLES - 1);
        end
      end
      MDU: begin
        idex_bubble = 1'b0;
        ex_hold     = 1'b1;
        w_cnt_next  = r_cnt - 1'b1;
        // Leave as the counter steps to zero so MDU spans MDU_CYCLES-1 cycles.
        if (r_cnt <= DW'(1)) w_next = RUN;
      end
      default: begin
      end
    endcase
  end

  assign w_stall_inc = ((r_state == RUN) || (r_state == MDU)) && !front_le;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_stall_inc && (r_stall != {CNT_W{1'b1}}))
        r_stall <= r_stall + 1'b1;
    end
  end

  assign state       = r_state;
  assign stall_count = r_stall;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer; a second CNT_W=4 instance shares the
// stimulus to exercise stall counter saturation.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        S, halt, id_uses_rt, ex_load, mdu_start;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        front_le, idex_bubble, ex_hold;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic        s_front_le, s_idex_bubble, s_ex_hold;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_count;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.MDU_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .S(S), .halt(halt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_load(ex_load), .ex_rt(ex_rt), .mdu_start(mdu_start),
    .front_le(front_le), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
    .state(state), .stall_count(stall_count));

  pipeline_sequencer #(.MDU_CYCLES(4), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .S(S), .halt(halt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_load(ex_load), .ex_rt(ex_rt), .mdu_start(mdu_start),
    .front_le(s_front_le), .idex_bubble(s_idex_bubble), .ex_hold(s_ex_hold),
    .state(s_state), .stall_count(s_stall_count));

  task automatic clear_inputs();
    S = 0; halt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_load = 0; ex_rt = 0; mdu_start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd0 || front_le !== 1'b0 || idex_bubble !== 1'b1 ||
        ex_hold !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%0d fle=%b bub=%b hold=%b sc=%0d want 0 0 1 0 0",
               state, front_le, idex_bubble, ex_hold, stall_count);
    end
    @(negedge clk);
    reset = 1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd0 || front_le !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL idle_wait: got st=%0d fle=%b bub=%b want 0 0 1", state, front_le, idex_bubble);
    end
    S = 1;
    @(negedge clk);
    S = 0;
    #1;
    checks++;
    if (state !== 2'd1 || front_le !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL start_run: got st=%0d fle=%b bub=%b want 1 1 0", state, front_le, idex_bubble);
    end
  endtask

  task automatic test_luh_rs();
    ex_load = 1; ex_rt = 5; id_rs = 5;
    #1;
    checks++;
    if (front_le !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL luh_rs_stall: got fle=%b bub=%b want 0 1", front_le, idex_bubble);
    end
    @(negedge clk);
    clear_inputs();
    exp_sc++;
    #1;
    checks++;
    if (state !== 2'd1 || front_le !== 1'b1 || idex_bubble !== 1'b0 || stall_count !== 16'(exp_sc)) begin
      errors++;
      $display("FAIL luh_rs_one_cycle: got st=%0d fle=%b bub=%b sc=%0d want 1 1 0 %0d",
               state, front_le, idex_bubble, stall_count, exp_sc);
    end
    ex_load = 1; ex_rt = 0; id_rs = 0;
    #1;
    checks++;
    if (front_le !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL luh_r0_nostall: got fle=%b bub=%b want 1 0", front_le, idex_bubble);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (stall_count !== 16'(exp_sc)) begin
      errors++;
      $display("FAIL luh_r0_count: got sc=%0d want %0d", stall_count, exp_sc);
    end
  endtask

  task automatic test_luh_rt();
    ex_load = 1; ex_rt = 7; id_rt = 7; id_rs = 3; id_uses_rt = 0;
    #1;
    checks++;
    if (front_le !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL luh_rt_unused: got fle=%b bub=%b want 1 0", front_le, idex_bubble);
    end
    @(negedge clk);
    id_uses_rt = 1;
    #1;
    checks++;
    if (front_le !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL luh_rt_used: got fle=%b bub=%b want 0 1", front_le, idex_bubble);
    end
    @(negedge clk);
    clear_inputs();
    exp_sc++;
    #1;
    checks++;
    if (stall_count !== 16'(exp_sc) || state !== 2'd1) begin
      errors++;
      $display("FAIL luh_rt_count: got sc=%0d st=%0d want %0d 1", stall_count, state, exp_sc);
    end
  endtask

  task automatic test_mdu();
    int n;
    mdu_start = 1;
    #1;
    checks++;
    if (front_le !== 1'b1 || ex_hold !== 1'b0 || idex_bubble !== 1'b0) begin
      errors++;
      $display("FAIL mdu_issue_outputs: got fle=%b hold=%b bub=%b want 1 0 0", front_le, ex_hold, idex_bubble);
    end
    @(negedge clk);
    mdu_start = 0;
    // hazard and halt inputs must be ignored while in MDU
    halt = 1; ex_load = 1; ex_rt = 4; id_rs = 4;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (state !== 2'd2) break;
      n++;
      checks++;
      if (ex_hold !== 1'b1 || front_le !== 1'b0 || idex_bubble !== 1'b0) begin
        errors++;
        $display("FAIL mdu_outputs: got hold=%b fle=%b bub=%b want 1 0 0", ex_hold, front_le, idex_bubble);
      end
      @(negedge clk);
    end
    clear_inputs();
    exp_sc += 3;
    #1;
    checks++;
    if (n != 3 || state !== 2'd1 || stall_count !== 16'(exp_sc)) begin
      errors++;
      $display("FAIL mdu_length: got cycles=%0d st=%0d sc=%0d want 3 1 %0d", n, state, stall_count, exp_sc);
    end
  endtask

  task automatic test_saturate();
    ex_load = 1; ex_rt = 9; id_rs = 9;
    repeat (20) @(negedge clk);
    clear_inputs();
    exp_sc += 20;
    #1;
    checks++;
    if (s_stall_count !== 4'd15) begin
      errors++;
      $display("FAIL sat_cnt4: got sc=%0d want 15", s_stall_count);
    end
    checks++;
    if (stall_count !== 16'(exp_sc)) begin
      errors++;
      $display("FAIL sat_cnt16: got sc=%0d want %0d", stall_count, exp_sc);
    end
  endtask

  task automatic test_halt();
    halt = 1; mdu_start = 1; ex_load = 1; ex_rt = 2; id_rs = 2;
    #1;
    checks++;
    if (front_le !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL halt_luh_outputs: got fle=%b bub=%b want 0 1", front_le, idex_bubble);
    end
    @(negedge clk);
    clear_inputs();
    exp_sc++;
    #1;
    checks++;
    if (state !== 2'd3 || ex_hold !== 1'b0 || front_le !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL halt_enter: got st=%0d hold=%b fle=%b bub=%b want 3 0 0 1",
               state, ex_hold, front_le, idex_bubble);
    end
    for (int i = 0; i < 3; i++) begin
      S = 1; @(negedge clk);
      S = 0; @(negedge clk);
    end
    #1;
    checks++;
    if (state !== 2'd3 || stall_count !== 16'(exp_sc)) begin
      errors++;
      $display("FAIL halt_sticky: got st=%0d sc=%0d want 3 %0d", state, stall_count, exp_sc);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (state !== 2'd0 || stall_count !== 16'd0 || s_stall_count !== 4'd0) begin
      errors++;
      $display("FAIL halt_async_reset: got st=%0d sc=%0d sc4=%0d want 0 0 0", state, stall_count, s_stall_count);
    end
    exp_sc = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_reset_mid_mdu();
    S = 1; @(negedge clk);
    S = 0; mdu_start = 1; @(negedge clk);
    mdu_start = 0;
    #1;
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL mdu_reenter: got st=%0d want 2", state);
    end
    #2 reset = 0;
    #1;
    checks++;
    if (state !== 2'd0 || ex_hold !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL mdu_abort: got st=%0d hold=%b sc=%0d want 0 0 0", state, ex_hold, stall_count);
    end
    @(negedge clk);
    reset = 1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd0 || front_le !== 1'b0 || idex_bubble !== 1'b1) begin
      errors++;
      $display("FAIL mdu_abort_idle: got st=%0d fle=%b bub=%b want 0 0 1", state, front_le, idex_bubble);
    end
  endtask

  initial begin
    test_reset();
    test_luh_rs();
    test_luh_rt();
    test_mdu();
    test_saturate();
    test_halt();
    test_reset_mid_mdu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Parameters
REQ-001 The block SHALL have parameter MDU_CYCLES, default 4, meaning the number of cycles a multi-cycle EX operation occupies (legal range 2..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.

Interface
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 S  input  1  start request; sampled only in IDLE.
REQ-006 halt  input  1  halt request from the decoded instruction in ID.
REQ-007 id_rs  input  5  rs field of the instruction in ID.
REQ-008 id_rt  input  5  rt field of the instruction in ID.
REQ-009 id_uses_rt  input  1  the ID instruction reads rt as a source.
REQ-010 ex_load  input  1  the EX instruction is a load.
REQ-011 ex_rt  input  5  destination register of the EX load.
REQ-012 mdu_start  input  1  the EX instruction is a multi-cycle multiply/divide.
REQ-013 front_le  output  1  load enable for PC, nPC and the IF/ID register.
REQ-014 idex_bubble  output  1  forces the ID/EX control word to NOP.
REQ-015 ex_hold  output  1  freezes the ID/EX and EX/MEM registers.
REQ-016 state  output  2  current FSM state encoding.
REQ-017 stall_count  output  CNT_W  cycles with front_le=0 while in RUN or MDU.

Function
REQ-018 The FSM SHALL have the states IDLE=0, RUN=1, MDU=2 and HALT=3.
REQ-019 IDLE outputs: front_le=0, idex_bubble=1, ex_hold=0; S=1 -> RUN on the next edge.
REQ-020 The hazard term luh SHALL be ex_load & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-021 RUN, no event: front_le=1, idex_bubble=0, ex_hold=0.
REQ-022 RUN with luh=1 (combinational, same cycle): front_le=0, idex_bubble=1, and the state SHALL remain RUN; the stall lasts exactly one cycle per hazard instance.
REQ-023 RUN with mdu_start=1: the next state SHALL be MDU, and the down-counter SHALL load MDU_CYCLES-1; outputs in that cycle SHALL be those of RUN.
REQ-024 MDU: front_le=0, idex_bubble=0, ex_hold=1; the counter SHALL decrement each cycle; when it reaches 0, the next state SHALL be RUN, so MDU lasts exactly MDU_CYCLES-1 cycles.
REQ-025 RUN with halt=1: the next state SHALL be HALT; HALT outputs: front_le=0, idex_bubble=1, ex_hold=0; the only exit SHALL be reset.
REQ-026 Priority in RUN SHALL be halt > mdu_start > luh; when halt=1, the luh outputs of that cycle still apply.
REQ-027 S SHALL be ignored outside IDLE; halt, mdu_start and luh SHALL be ignored in IDLE, MDU and HALT.
REQ-028 stall_count SHALL increment by 1 on each edge where the state is RUN or MDU and front_le=0, and SHALL saturate at all-ones without wrapping.
REQ-029 state SHALL equal the registered FSM state; all outputs except state and stall_count SHALL be combinational from the state and the inputs.

Reset
REQ-030 While reset=0, the block SHALL force state=IDLE, the down-counter to 0 and stall_count to 0 immediately, independent of clk.
REQ-031 Reset asserted mid-MDU or in HALT SHALL abandon the operation; after release the block SHALL wait in IDLE for S.
REQ-032 Out of reset the outputs SHALL be front_le=0, idex_bubble=1, ex_hold=0, state=0, stall_count=0.

Verification
REQ-033 Bench: reset low, then high, S=0 for 5 cycles -> state=0, front_le=0, idex_bubble=1; S=1 -> state=1 after 1 edge, front_le=1.
REQ-034 Bench: RUN, ex_load=1, ex_rt=5, id_rs=5 for one cycle -> front_le=0 and idex_bubble=1 that cycle only, stall_count=1; repeat with ex_rt=0 -> no stall.
REQ-035 Bench: RUN, ex_load=1, ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall; with id_uses_rt=1 -> stall.
REQ-036 Bench: RUN, mdu_start=1 with MDU_CYCLES=4 -> state=2 for exactly 3 cycles with ex_hold=1, then state=1; stall_count increases by 3.
REQ-037 Bench: RUN, halt=1 and mdu_start=1 in the same cycle -> state=3, ex_hold=0; S pulses do not change the state; reset low -> state=0 asynchronously, stall_count=0.
REQ-038 Bench: with CNT_W=4, force 20 stall cycles -> stall_count holds at 15.
